// File: rtl/arm_mul_pkg.sv
// Shared types and constants for the iterative ARM multiplier.
package arm_mul_pkg;

    typedef enum logic [1:0] {
        MUL   = 2'b00,
        UMULL = 2'b01,
        SMULL = 2'b10,
        MLA   = 2'b11
    } mul_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [1:0] FLAGW_NZ   = 2'b10;
    localparam logic [1:0] FLAGW_NONE = 2'b00;

endpackage

// File: rtl/arm_mul_step.sv
// One radix-2 shift-add iteration: conditional add into hi, then shift
// {carry,hi,lo,multiplier} right by one.
module arm_mul_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] mplier_i,
    input  logic [WIDTH-1:0] mcand_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] mplier_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum      = {1'b0, hi_i} + (mplier_i[0] ? {1'b0, mcand_i} : '0);
        hi_o     = sum[WIDTH:1];
        lo_o     = {sum[0], lo_i[WIDTH-1:1]};
        mplier_o = {lo_i[0], mplier_i[WIDTH-1:1]};
    end

endmodule

// File: rtl/arm_mul_unit.sv
// Iterative multiplier (MUL/UMULL/SMULL, optional MLA) with start/busy/done.
// Define ARM_MUL_MLA_EN to build the MLA accumulate path; otherwise op 11 runs as MUL.
module arm_mul_unit
    import arm_mul_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic [1:0]       flagw
);

    state_t             state_q, state_d;
    mul_op_t            op_q, op_acc;
    logic               sign_q;
    logic [WIDTH-1:0]   mcand_q, mplier_q, hi_q, lo_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         flags_q;
    logic               accept;

    logic [WIDTH-1:0]   step_hi, step_lo, step_mplier;
    logic [2*WIDTH-1:0] fix_prod;
    logic [3:0]         fix_flags;
    logic               smull_acc;
    logic [WIDTH-1:0]   a_mag, b_mag;

`ifdef ARM_MUL_MLA_EN
    logic [WIDTH-1:0]   acc_q;
`else
    logic               unused_acc;
    assign unused_acc = ^acc;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        flagw   = FLAGW_NONE;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = FIX;
            end
            FIX: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done  = 1'b1;
                flagw = FLAGW_NZ;
                if (start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_acc = mul_op_t'(op);
`ifndef ARM_MUL_MLA_EN
        if (op_acc == MLA) op_acc = MUL;
`endif
        smull_acc = (op_acc == SMULL);
        a_mag     = (smull_acc && a[WIDTH-1]) ? -a : a;
        b_mag     = (smull_acc && b[WIDTH-1]) ? -b : b;
    end

    arm_mul_step #(.WIDTH(WIDTH)) u_step (
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .mplier_i (mplier_q),
        .mcand_i  (mcand_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo),
        .mplier_o (step_mplier)
    );

    // Post-processing: sign fix-up, accumulate, truncate 32-bit ops, flags.
    always_comb begin
        fix_prod = {hi_q, lo_q};
        if (op_q == SMULL && sign_q) fix_prod = -{hi_q, lo_q};
`ifdef ARM_MUL_MLA_EN
        if (op_q == MLA) fix_prod[WIDTH-1:0] = lo_q + acc_q;
`endif
        if (op_q == MUL || op_q == MLA) fix_prod[2*WIDTH-1:WIDTH] = '0;
        fix_flags = 4'b0000;
        if (op_q == MUL || op_q == MLA) begin
            fix_flags[3] = fix_prod[WIDTH-1];
            fix_flags[2] = (fix_prod[WIDTH-1:0] == '0);
        end else begin
            fix_flags[3] = fix_prod[2*WIDTH-1];
            fix_flags[2] = (fix_prod == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= MUL;
            sign_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            flags_q  <= '0;
`ifdef ARM_MUL_MLA_EN
            acc_q    <= '0;
`endif
        end else if (accept) begin
            op_q     <= op_acc;
            sign_q   <= smull_acc & (a[WIDTH-1] ^ b[WIDTH-1]);
            mcand_q  <= a_mag;
            mplier_q <= b_mag;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= CNT_W'(WIDTH);
            flags_q  <= '0;
`ifdef ARM_MUL_MLA_EN
            acc_q    <= acc;
`endif
        end else if (state_q == RUN) begin
            hi_q     <= step_hi;
            lo_q     <= step_lo;
            mplier_q <= step_mplier;
            cnt_q    <= cnt_q - CNT_W'(1);
        end else if (state_q == FIX) begin
            hi_q     <= fix_prod[2*WIDTH-1:WIDTH];
            lo_q     <= fix_prod[WIDTH-1:0];
            flags_q  <= fix_flags;
        end
    end

    assign result_lo = lo_q;
    assign result_hi = hi_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_arm_mul_unit.sv
// Self-checking bench for arm_mul_unit (WIDTH=32): vector table plus handshake corner cases.
module tb_arm_mul_unit;

    localparam int W = 32;
    localparam int LAT = W + 2;

`ifdef ARM_MUL_MLA_EN
    localparam logic [31:0] MLA_EXP = 32'd22;
`else
    localparam logic [31:0] MLA_EXP = 32'd12;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  a = '0, b = '0, acc = '0;
    logic          busy, done;
    logic [W-1:0]  result_lo, result_hi;
    logic [3:0]    flags;
    logic [1:0]    flagw;

    int n_cmp = 0;
    int n_bad = 0;

    arm_mul_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .acc(acc),
        .busy(busy), .done(done),
        .result_lo(result_lo), .result_hi(result_hi),
        .flags(flags), .flagw(flagw)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, acc;
        logic [31:0] lo, hi;
        logic [3:0]  fl;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one start pulse; returns at the falling edge of the first post-accept cycle.
    task automatic issue(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] vacc);
        @(negedge clk);
        op = o; a = va; b = vb; acc = vacc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit busy_ok);
        lat = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        bit bok;
        int ndone;
        logic [31:0] seen_lo;
        logic [3:0]  seen_fl;

        vecs[0]  = '{2'b00, 32'd7,        32'd6,        32'd0,  32'h0000002A, 32'h0,        4'b0000};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,  32'h00000001, 32'hFFFFFFFE, 4'b1000};
        vecs[2]  = '{2'b10, 32'hFFFFFFFD, 32'd5,        32'd0,  32'hFFFFFFF1, 32'hFFFFFFFF, 4'b1000};
        vecs[3]  = '{2'b10, 32'h80000000, 32'h80000000, 32'd0,  32'h0,        32'h40000000, 4'b0000};
        vecs[4]  = '{2'b00, 32'd0,        32'h1234,     32'd0,  32'h0,        32'h0,        4'b0100};
        vecs[5]  = '{2'b11, 32'd3,        32'd4,        32'd10, MLA_EXP,      32'h0,        4'b0000};
        vecs[6]  = '{2'b01, 32'h12345678, 32'h10,       32'd0,  32'h23456780, 32'h1,        4'b0000};
        vecs[7]  = '{2'b00, 32'h10000,    32'h10000,    32'd0,  32'h0,        32'h0,        4'b0100};
        vecs[8]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,  32'h1,        32'h0,        4'b0000};
        vecs[9]  = '{2'b10, 32'd0,        32'hFFFFFFFB, 32'd0,  32'h0,        32'h0,        4'b0100};
        vecs[10] = '{2'b00, 32'hFFFFFFFF, 32'd2,        32'd0,  32'hFFFFFFFE, 32'h0,        4'b1000};
        vecs[11] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd0,  32'hFFFFFFF2, 32'hFFFFFFFF, 4'b1000};

        repeat (3) @(negedge clk);
        chk("rst_busy",  {63'd0, busy}, 64'd0);
        chk("rst_done",  {63'd0, done}, 64'd0);
        chk("rst_res",   {result_hi, result_lo}, 64'd0);
        chk("rst_flags", {60'd0, flags}, 64'd0);
        chk("rst_flagw", {62'd0, flagw}, 64'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].acc);
            wait_done(lat, bok);
            chk($sformatf("v%0d_lat", i),   lat, LAT);
            chk($sformatf("v%0d_busy", i),  {63'd0, bok}, 64'd1);
            chk($sformatf("v%0d_lo", i),    {32'd0, result_lo}, {32'd0, vecs[i].lo});
            chk($sformatf("v%0d_hi", i),    {32'd0, result_hi}, {32'd0, vecs[i].hi});
            chk($sformatf("v%0d_flags", i), {60'd0, flags}, {60'd0, vecs[i].fl});
            chk($sformatf("v%0d_flagw", i), {62'd0, flagw}, 64'd2);
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i), {62'd0, done, busy}, 64'd0);
            chk($sformatf("v%0d_hold", i),  {result_hi, result_lo}, {vecs[i].hi, vecs[i].lo});
        end

        // Start while busy is ignored; exactly one done.
        issue(2'b00, 32'd0, 32'h1234, 32'd0);
        ndone = 0;
        seen_lo = 32'hDEADBEEF;
        seen_fl = 4'hF;
        for (int k = 1; k <= 80; k++) begin
            if (done === 1'b1) begin
                ndone++;
                seen_lo = result_lo;
                seen_fl = flags;
                chk("ign_cycle", k, LAT);
            end
            if (k == 10) begin
                op = 2'b01; a = 32'd5; b = 32'd5; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("ign_ndone", ndone, 1);
        chk("ign_lo",    {32'd0, seen_lo}, 64'd0);
        chk("ign_flags", {60'd0, seen_fl}, 64'h4);

        // Reset during RUN aborts with zeroed outputs and no done.
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy",  {63'd0, busy}, 64'd0);
        chk("abort_done",  {63'd0, done}, 64'd0);
        chk("abort_res",   {result_hi, result_lo}, 64'd0);
        chk("abort_flags", {58'd0, flags, flagw}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1 || busy === 1'b1) ndone++;
            @(negedge clk);
        end
        chk("abort_quiet", ndone, 0);
        issue(2'b00, 32'd2, 32'd3, 32'd0);
        wait_done(lat, bok);
        chk("after_abort_lat", lat, LAT);
        chk("after_abort_lo",  {32'd0, result_lo}, 64'd6);

        // MLA followed by a MUL issued in its DONE cycle.
        issue(2'b11, 32'd3, 32'd4, 32'd10);
        wait_done(lat, bok);
        chk("mla_lat", lat, LAT);
        chk("mla_lo",  {32'd0, result_lo}, {32'd0, MLA_EXP});
        op = 2'b00; a = 32'd5; b = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        wait_done(lat, bok);
        chk("b2b_lat",  lat, LAT);
        chk("b2b_run",  {63'd0, bok}, 64'd1);
        chk("b2b_lo",   {32'd0, result_lo}, 64'd30);
        chk("b2b_hi",   {32'd0, result_hi}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
